// File: rtl/em_project_vga.sv
// em_project_vga: VGA 640x480@60 timing generator running on the 50 MHz
// board clock. A registered divide-by-2 (pll_clk) acts as the 25 MHz pixel
// enable, and a short lock counter stands in for PLL lock.
//
// Ports:
//   CLOCK_50    in   1   system clock, the only clock
//   reset_P     in   1   synchronous active-high reset
//   KEY         in   4   active-low pushbuttons (asynchronous, synchronized here)
//   pll_clk     out  1   divide-by-2 of CLOCK_50; a pixel step happens when it is 1
//   pll_locked  out  1   high once the lock counter reaches LOCK_CYCLES
//   horz_count  out  12  pixel column, 0..H_TOTAL-1
//   vert_count  out  12  line number, 0..V_TOTAL-1
//   horz_sync   out  1   active-low horizontal sync
//   vert_sync   out  1   active-low vertical sync
//   v_on        out  1   high inside the visible area
//
// Effective reset is reset_P or a pressed KEY[0] (after synchronization).
//
// Optional feature, macro EM_PROJECT_KEY_PAUSE_EN: while the synchronized
// KEY[1] is pressed, horz_count/vert_count hold (syncs and v_on follow the
// held counts). Without the macro KEY[3:1] are ignored.
//
// There is no FSM in this block; the full internal state (divider, lock
// counter, pixel counters) is already visible on the output ports.

module em_project_vga #(
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int LOCK_CYCLES = 16
) (
    input  logic        CLOCK_50,
    input  logic        reset_P,
    input  logic [3:0]  KEY,
    output logic        pll_clk,
    output logic        pll_locked,
    output logic [11:0] horz_count,
    output logic [11:0] vert_count,
    output logic        horz_sync,
    output logic        vert_sync,
    output logic        v_on
);

    localparam logic [11:0] H_TOTAL      = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam logic [11:0] V_TOTAL      = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP);
    localparam logic [11:0] H_VIS        = 12'(H_ACTIVE);
    localparam logic [11:0] V_VIS        = 12'(V_ACTIVE);
    localparam logic [11:0] H_SYNC_FIRST = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] H_SYNC_LAST  = 12'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [11:0] V_SYNC_FIRST = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] V_SYNC_LAST  = 12'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam int          LOCK_W       = $clog2(LOCK_CYCLES + 1);
    localparam logic [LOCK_W-1:0] LOCK_DONE = LOCK_W'(LOCK_CYCLES);

    logic [3:0]        key_meta;
    logic [3:0]        key_sync;
    logic [LOCK_W-1:0] lock_count;
    logic              rst;
    logic              advance;

    // Two-flop synchronizer. Deliberately not reset: its output feeds the
    // reset term, and clearing it would stretch every reset_P pulse.
    always_ff @(posedge CLOCK_50) begin
        key_meta <= KEY;
        key_sync <= key_meta;
    end

    assign rst        = reset_P | ~key_sync[0];
    assign pll_locked = (lock_count == LOCK_DONE);

`ifdef EM_PROJECT_KEY_PAUSE_EN
    logic unused_keys;
    assign unused_keys = &{1'b0, key_sync[3:2]};
    // A held KEY[1] suppresses pixel steps; divider and lock keep running.
    assign advance = pll_locked & pll_clk & key_sync[1];
`else
    logic unused_keys;
    assign unused_keys = &{1'b0, key_sync[3:1]};
    assign advance = pll_locked & pll_clk;
`endif

    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            pll_clk    <= 1'b0;
            lock_count <= '0;
            horz_count <= '0;
            vert_count <= '0;
        end else begin
            pll_clk <= ~pll_clk;
            if (lock_count != LOCK_DONE) begin
                lock_count <= lock_count + 1'b1;
            end
            if (advance) begin
                if (horz_count == H_TOTAL - 12'd1) begin
                    horz_count <= '0;
                    // Line advances only on the step where the column wraps,
                    // so both counters can wrap on the same step.
                    if (vert_count == V_TOTAL - 12'd1) begin
                        vert_count <= '0;
                    end else begin
                        vert_count <= vert_count + 12'd1;
                    end
                end else begin
                    horz_count <= horz_count + 12'd1;
                end
            end
        end
    end

    // Zero-latency decode from the counter registers; syncs stay inactive
    // and video stays off until lock.
    always_comb begin
        horz_sync = ~(pll_locked & (horz_count >= H_SYNC_FIRST) & (horz_count <= H_SYNC_LAST));
        vert_sync = ~(pll_locked & (vert_count >= V_SYNC_FIRST) & (vert_count <= V_SYNC_LAST));
        v_on      = pll_locked & (horz_count < H_VIS) & (vert_count < V_VIS);
    end

endmodule

// File: tb/tb_em_project_vga.sv
// Bench for em_project_vga. Two instances share the inputs: one with the
// real 640x480 timing (horizontal boundaries, line wrap) and one with a
// shrunken frame so vertical sync and frame wrap occur within a short run.
// The reference model counts pixel steps since reset and maps them to
// (column, line) with division and modulo.

module tb_em_project_vga;

    localparam int LOCK = 16;
    // Small-frame geometry for the second instance.
    localparam int S_HA = 20, S_HFP = 4, S_HS = 6, S_HBP = 2;
    localparam int S_VA = 6,  S_VFP = 2, S_VS = 2, S_VBP = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #10 clk = ~clk;   // 50 MHz

    logic       reset_P;
    logic [3:0] KEY;

    logic        d_pll_clk, d_pll_locked, d_horz_sync, d_vert_sync, d_v_on;
    logic [11:0] d_horz_count, d_vert_count;
    logic        s_pll_clk, s_pll_locked, s_horz_sync, s_vert_sync, s_v_on;
    logic [11:0] s_horz_count, s_vert_count;

    em_project_vga dut_full (
        .CLOCK_50   (clk),
        .reset_P    (reset_P),
        .KEY        (KEY),
        .pll_clk    (d_pll_clk),
        .pll_locked (d_pll_locked),
        .horz_count (d_horz_count),
        .vert_count (d_vert_count),
        .horz_sync  (d_horz_sync),
        .vert_sync  (d_vert_sync),
        .v_on       (d_v_on)
    );

    em_project_vga #(
        .H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
        .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP),
        .LOCK_CYCLES(LOCK)
    ) dut_small (
        .CLOCK_50   (clk),
        .reset_P    (reset_P),
        .KEY        (KEY),
        .pll_clk    (s_pll_clk),
        .pll_locked (s_pll_locked),
        .horz_count (s_horz_count),
        .vert_count (s_vert_count),
        .horz_sync  (s_horz_sync),
        .vert_sync  (s_vert_sync),
        .v_on       (s_v_on)
    );

    // ---------------- scoreboard state ----------------
    logic [57:0] exp_q[$];
    int checks   = 0;
    int failures = 0;

    // Expected outputs after t non-reset cycles with `steps` pixel steps taken.
    // Packing: {pll_clk, locked, hc[11:0], vc[11:0], hsync, vsync, v_on}.
    function automatic logic [28:0] model_out(input int t, input int steps,
                                              input int ha, input int hfp, input int hsw, input int hbp,
                                              input int va, input int vfp, input int vsw, input int vbp);
        int ht, vt, pos, hc, vc;
        logic lk, hs, vs, von;
        ht  = ha + hfp + hsw + hbp;
        vt  = va + vfp + vsw + vbp;
        pos = steps % (ht * vt);
        hc  = pos % ht;
        vc  = pos / ht;
        lk  = (t >= LOCK);
        hs  = !(lk && hc >= ha + hfp && hc < ha + hfp + hsw);
        vs  = !(lk && vc >= va + vfp && vc < va + vfp + vsw);
        von = lk && hc < ha && vc < va;
        return {1'(t % 2), lk, 12'(hc), 12'(vc), hs, vs, von};
    endfunction

    // ---------------- reference model ----------------
    // Runs at each rising edge, using the inputs held stable since the
    // previous edge, and pushes the state expected right after that edge.
    int         m_t = 0;
    int         m_steps = 0;
    logic [3:0] m_ks1 = 4'h0;
    logic [3:0] m_ks0 = 4'h0;
    logic       m_rst, m_pause;

    initial begin
        forever begin
            @(posedge clk);
            m_rst = reset_P | ~m_ks0[0];
`ifdef EM_PROJECT_KEY_PAUSE_EN
            m_pause = ~m_ks0[1];
`else
            m_pause = 1'b0;
`endif
            if (m_rst) begin
                m_t     = 0;
                m_steps = 0;
            end else begin
                // A pixel step needs lock and the divider high before the edge.
                if (m_t >= LOCK && (m_t % 2) == 1 && !m_pause) m_steps = m_steps + 1;
                m_t = m_t + 1;
            end
            m_ks0 = m_ks1;
            m_ks1 = KEY;
            exp_q.push_back({model_out(m_t, m_steps, 640, 16, 96, 48, 480, 10, 2, 33),
                             model_out(m_t, m_steps, S_HA, S_HFP, S_HS, S_HBP, S_VA, S_VFP, S_VS, S_VBP)});
        end
    end

    // ---------------- monitor ----------------
    task automatic check_field(input string name, input logic [11:0] act, input logic [11:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic check_dut(input string tag, input logic [28:0] act, input logic [28:0] exp);
        check_field({tag, ".pll_clk"},    12'(act[28]),    12'(exp[28]));
        check_field({tag, ".pll_locked"}, 12'(act[27]),    12'(exp[27]));
        check_field({tag, ".horz_count"}, act[26:15],      exp[26:15]);
        check_field({tag, ".vert_count"}, act[14:3],       exp[14:3]);
        check_field({tag, ".horz_sync"},  12'(act[2]),     12'(exp[2]));
        check_field({tag, ".vert_sync"},  12'(act[1]),     12'(exp[1]));
        check_field({tag, ".v_on"},       12'(act[0]),     12'(exp[0]));
    endtask

    initial begin
        logic [57:0] e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_dut("full", {d_pll_clk, d_pll_locked, d_horz_count, d_vert_count,
                                   d_horz_sync, d_vert_sync, d_v_on}, e[57:29]);
                check_dut("small", {s_pll_clk, s_pll_locked, s_horz_count, s_vert_count,
                                    s_horz_sync, s_vert_sync, s_v_on}, e[28:0]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            // Occasionally change the non-reset buttons; KEY[0] stays released.
            if ($urandom_range(0, 63) == 0) KEY[3:1] = 3'($urandom_range(0, 7));
        end
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        reset_P = 1'b1;
        @(posedge clk); #1;
        reset_P = 1'b0;
    endtask

    task automatic press_key0(input int n);
        @(posedge clk); #1;
        KEY[0] = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        KEY[0] = 1'b1;
    endtask

    // ---------------- stimulus + report ----------------
    initial begin
        reset_P = 1'b1;
        KEY     = 4'b0000;
        repeat (5) @(posedge clk);   // 100 ns with everything asserted
        #1;
        reset_P = 1'b0;
        KEY     = 4'b1111;

        // Past two full 800-pixel lines on the real geometry.
        run_cycles(3400 + int'($urandom_range(0, 100)));
        pulse_reset();
        run_cycles(900 + int'($urandom_range(0, 200)));
        press_key0(int'($urandom_range(1, 4)));
        run_cycles(600 + int'($urandom_range(0, 300)));
        pulse_reset();
        KEY[3:1] = 3'b111;
        run_cycles(1800);

        // Let the monitor drain, bounded.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        @(negedge clk);
        checks = checks + 1;
        if (exp_q.size() > 1) begin
            failures = failures + 1;
            $display("FAIL drain: got %0d pending expected at most 1", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
